// File: rtl/pll_reconfig_ctrl_if.sv
// rtl/pll_reconfig_ctrl_if.sv - configuration request/response bundle for pll_reconfig_ctrl
interface pll_reconfig_ctrl_if;
    logic        cfg_req;
    logic [31:0] cfg_M;
    logic [31:0] cfg_D;
    logic [31:0] cfg_O;
    logic        cfg_ack;
    logic        cfg_err;

    modport master (
        output cfg_req, cfg_M, cfg_D, cfg_O,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_req, cfg_M, cfg_D, cfg_O,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - frequency generator reconfiguration, reset hold and lock sequencer
module pll_reconfig_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter int unsigned LOCK_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               PWRDWN,
    input  logic               period_stable,
    pll_reconfig_ctrl_if.slave cfg,
    output logic [31:0]        M,
    output logic [31:0]        D,
    output logic [31:0]        O,
    output logic               gen_rst,
    output logic               gen_pwrdwn,
    output logic               LOCKED,
    output logic               busy,
    output logic               timeout
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT,
        S_COUNT,
        S_LOCK
    } state_t;

    localparam logic [15:0] HOLD_LAST    = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state;
    logic [15:0] r_cnt, w_cnt;
    logic [31:0] r_m, w_m, r_d, w_d, r_o, w_o;
    logic        r_gen_rst, w_gen_rst;
    logic        r_gen_pwrdwn, w_gen_pwrdwn;
    logic        r_locked, w_locked;
    logic        r_busy, w_busy;
    logic        r_timeout, w_timeout;
    logic        r_ack, w_ack;
    logic        r_err, w_err;
    logic        r_configured, w_configured;
    logic        w_cfg_valid;

    assign w_cfg_valid = (cfg.cfg_M >= 32'd2) && (cfg.cfg_M <= 32'd64) &&
                         (cfg.cfg_D >= 32'd1) && (cfg.cfg_D <= 32'd56) &&
                         (cfg.cfg_O >= 32'd1) && (cfg.cfg_O <= 32'd128);

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_m          = r_m;
        w_d          = r_d;
        w_o          = r_o;
        w_gen_rst    = r_gen_rst;
        w_gen_pwrdwn = r_gen_pwrdwn;
        w_locked     = r_locked;
        w_timeout    = r_timeout;
        w_configured = r_configured;
        w_ack        = 1'b0;
        w_err        = 1'b0;

        if (PWRDWN) begin
            w_state      = S_IDLE;
            w_cnt        = '0;
            w_gen_pwrdwn = 1'b1;
            w_locked     = 1'b0;
        end else if (r_gen_pwrdwn) begin
            // Leaving power-down: restart the generator only if it ever had a valid setting.
            w_gen_pwrdwn = 1'b0;
            w_gen_rst    = 1'b1;
            w_cnt        = '0;
            w_state      = r_configured ? S_HOLD : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_LOCK: begin
                    if (cfg.cfg_req) begin
                        if (w_cfg_valid) begin
                            w_m          = cfg.cfg_M;
                            w_d          = cfg.cfg_D;
                            w_o          = cfg.cfg_O;
                            w_ack        = 1'b1;
                            w_locked     = 1'b0;
                            w_gen_rst    = 1'b1;
                            w_timeout    = 1'b0;
                            w_configured = 1'b1;
                            w_cnt        = '0;
                            w_state      = S_HOLD;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if ((r_state == S_LOCK) && !period_stable) begin
                        w_locked = 1'b0;
                        w_cnt    = '0;
                        w_state  = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_gen_rst = 1'b0;
                        w_cnt     = '0;
                        w_state   = S_WAIT;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (period_stable) begin
                        w_cnt   = '0;
                        w_state = S_COUNT;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_cnt     = '0;
                        w_gen_rst = 1'b1;
                        w_timeout = 1'b1;
                        w_state   = S_IDLE;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                S_COUNT: begin
                    // A stability drop beats the terminal count.
                    if (!period_stable) begin
                        w_cnt   = '0;
                        w_state = S_WAIT;
                    end else if (r_cnt == LOCK_LAST) begin
                        w_cnt    = '0;
                        w_locked = 1'b1;
                        w_state  = S_LOCK;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end
            endcase
        end

        w_busy = (w_state == S_HOLD) || (w_state == S_WAIT) || (w_state == S_COUNT);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_m          <= 32'd1;
            r_d          <= 32'd1;
            r_o          <= 32'd1;
            r_gen_rst    <= 1'b1;
            r_gen_pwrdwn <= 1'b0;
            r_locked     <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_configured <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_m          <= w_m;
            r_d          <= w_d;
            r_o          <= w_o;
            r_gen_rst    <= w_gen_rst;
            r_gen_pwrdwn <= w_gen_pwrdwn;
            r_locked     <= w_locked;
            r_busy       <= w_busy;
            r_timeout    <= w_timeout;
            r_ack        <= w_ack;
            r_err        <= w_err;
            r_configured <= w_configured;
        end
    end

    assign M           = r_m;
    assign D           = r_d;
    assign O           = r_o;
    assign gen_rst     = r_gen_rst;
    assign gen_pwrdwn  = r_gen_pwrdwn;
    assign LOCKED      = r_locked;
    assign busy        = r_busy;
    assign timeout     = r_timeout;
    assign cfg.cfg_ack = r_ack;
    assign cfg.cfg_err = r_err;
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - directed self-checking bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;
    logic        clk = 1'b0;
    logic        RST;
    logic        PWRDWN;
    logic        period_stable;
    logic [31:0] M, D, O;
    logic        gen_rst, gen_pwrdwn, LOCKED, busy, timeout;

    always #5 clk = ~clk;

    pll_reconfig_ctrl_if u_if ();

    pll_reconfig_ctrl dut (
        .clk           (clk),
        .RST           (RST),
        .PWRDWN        (PWRDWN),
        .period_stable (period_stable),
        .cfg           (u_if),
        .M             (M),
        .D             (D),
        .O             (O),
        .gen_rst       (gen_rst),
        .gen_pwrdwn    (gen_pwrdwn),
        .LOCKED        (LOCKED),
        .busy          (busy),
        .timeout       (timeout)
    );

    typedef struct packed {
        logic        is_ack;
        logic [31:0] m;
        logic [31:0] d;
        logic [31:0] o;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;

    logic [31:0] bad_tab [6][3] = '{
        '{32'd1,  32'd1,  32'd5},
        '{32'd10, 32'd1,  32'd129},
        '{32'd65, 32'd1,  32'd1},
        '{32'd10, 32'd0,  32'd1},
        '{32'd10, 32'd57, 32'd1},
        '{32'd10, 32'd1,  32'd0}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] m, input logic [31:0] d, input logic [31:0] o,
                             input logic ok, input logic [31:0] em, input logic [31:0] ed,
                             input logic [31:0] eo);
        u_if.cfg_M   = m;
        u_if.cfg_D   = d;
        u_if.cfg_O   = o;
        u_if.cfg_req = 1'b1;
        sb.push_back({ok, em, ed, eo});
    endtask

    task automatic wait_rst_low(output int cnt);
        cnt = 0;
        while (gen_rst && cnt < 100) begin
            step(1);
            cnt++;
        end
    endtask

    task automatic wait_locked(output int cnt);
        cnt = 0;
        while (!LOCKED && cnt < 200) begin
            step(1);
            cnt++;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_M"}, M, 32'd1);
        check({pfx, "_D"}, D, 32'd1);
        check({pfx, "_O"}, O, 32'd1);
        check({pfx, "_gen_rst"}, {31'b0, gen_rst}, 32'd1);
        check({pfx, "_gen_pwrdwn"}, {31'b0, gen_pwrdwn}, 32'd0);
        check({pfx, "_LOCKED"}, {31'b0, LOCKED}, 32'd0);
        check({pfx, "_busy"}, {31'b0, busy}, 32'd0);
        check({pfx, "_timeout"}, {31'b0, timeout}, 32'd0);
        check({pfx, "_ack"}, {31'b0, u_if.cfg_ack}, 32'd0);
        check({pfx, "_err"}, {31'b0, u_if.cfg_err}, 32'd0);
    endtask

    // Response scoreboard: every ack/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (u_if.cfg_ack === 1'b1 || u_if.cfg_err === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_unexpected_resp: observed ack=%0b err=%0b expected no response",
                       u_if.cfg_ack, u_if.cfg_err);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_ack", {31'b0, u_if.cfg_ack}, {31'b0, mon_e.is_ack});
                check("sb_err", {31'b0, u_if.cfg_err}, {31'b0, ~mon_e.is_ack});
                check("sb_M", M, mon_e.m);
                check("sb_D", D, mon_e.d);
                check("sb_O", O, mon_e.o);
            end
        end
    end

    initial begin
        RST           = 1'b1;
        PWRDWN        = 1'b0;
        period_stable = 1'b0;
        u_if.cfg_req  = 1'b0;
        u_if.cfg_M    = '0;
        u_if.cfg_D    = '0;
        u_if.cfg_O    = '0;
        step(3);
        check_reset_outputs("reset");

        // Basic accept and lock
        RST           = 1'b0;
        period_stable = 1'b1;
        drive_req(32'd10, 32'd1, 32'd5, 1'b1, 32'd10, 32'd1, 32'd5);
        step(1);
        u_if.cfg_req = 1'b0;
        check("acc_ack", {31'b0, u_if.cfg_ack}, 32'd1);
        check("acc_busy", {31'b0, busy}, 32'd1);
        wait_rst_low(n);
        check("acc_gen_rst_cycles", n, 32'd4);
        wait_locked(n);
        check("acc_lock_cycles", n, 32'd17);
        check("acc_busy_locked", {31'b0, busy}, 32'd0);
        check("acc_M", M, 32'd10);
        check("acc_D", D, 32'd1);
        check("acc_O", O, 32'd5);

        // Out-of-range requests while locked
        for (int i = 0; i < 6; i++) begin
            drive_req(bad_tab[i][0], bad_tab[i][1], bad_tab[i][2], 1'b0, 32'd10, 32'd1, 32'd5);
            step(1);
            check("bad_err", {31'b0, u_if.cfg_err}, 32'd1);
            check("bad_locked", {31'b0, LOCKED}, 32'd1);
        end
        u_if.cfg_req = 1'b0;
        step(1);
        check("bad_M_kept", M, 32'd10);
        check("bad_O_kept", O, 32'd5);

        // Reconfigure; second request held during busy; stability glitch at COUNT cycle 10
        drive_req(32'd20, 32'd2, 32'd3, 1'b1, 32'd20, 32'd2, 32'd3);
        step(1);
        check("re_ack", {31'b0, u_if.cfg_ack}, 32'd1);
        check("re_unlocked", {31'b0, LOCKED}, 32'd0);
        drive_req(32'd30, 32'd3, 32'd4, 1'b1, 32'd30, 32'd3, 32'd4);
        wait_rst_low(n);
        check("re_gen_rst_cycles", n, 32'd4);
        step(11);
        period_stable = 1'b0;
        step(1);
        check("glitch_busy", {31'b0, busy}, 32'd1);
        check("glitch_locked", {31'b0, LOCKED}, 32'd0);
        period_stable = 1'b1;
        step(1);
        wait_locked(n);
        check("glitch_fresh_cycles", n, 32'd16);
        step(1);
        check("held_ack_after_lock", {31'b0, u_if.cfg_ack}, 32'd1);
        check("held_M", M, 32'd30);
        u_if.cfg_req = 1'b0;
        wait_rst_low(n);
        check("held_gen_rst_cycles", n, 32'd4);
        wait_locked(n);
        check("held_lock_cycles", n, 32'd17);

        // Lose stability while locked
        period_stable = 1'b0;
        step(1);
        check("lockloss_locked", {31'b0, LOCKED}, 32'd0);
        check("lockloss_busy", {31'b0, busy}, 32'd1);
        check("lockloss_gen_rst", {31'b0, gen_rst}, 32'd0);
        period_stable = 1'b1;
        wait_locked(n);
        check("relock_cycles", n, 32'd17);

        // Power-down pulse while locked; requests during power-down are ignored
        PWRDWN       = 1'b1;
        u_if.cfg_M   = 32'd40;
        u_if.cfg_D   = 32'd4;
        u_if.cfg_O   = 32'd4;
        u_if.cfg_req = 1'b1;
        step(1);
        check("pd_gen_pwrdwn", {31'b0, gen_pwrdwn}, 32'd1);
        check("pd_locked", {31'b0, LOCKED}, 32'd0);
        check("pd_busy", {31'b0, busy}, 32'd0);
        step(4);
        u_if.cfg_req = 1'b0;
        PWRDWN       = 1'b0;
        step(1);
        check("pdrel_gen_pwrdwn", {31'b0, gen_pwrdwn}, 32'd0);
        check("pdrel_busy", {31'b0, busy}, 32'd1);
        wait_rst_low(n);
        check("pdrel_gen_rst_cycles", n, 32'd4);
        wait_locked(n);
        check("pdrel_lock_cycles", n, 32'd17);
        check("pdrel_M", M, 32'd30);
        check("pdrel_D", D, 32'd3);
        check("pdrel_O", O, 32'd4);

        // Upper-bound valid config, never stable -> timeout
        period_stable = 1'b0;
        drive_req(32'd64, 32'd56, 32'd128, 1'b1, 32'd64, 32'd56, 32'd128);
        step(1);
        u_if.cfg_req = 1'b0;
        wait_rst_low(n);
        check("to_gen_rst_cycles", n, 32'd4);
        n = 0;
        while (!timeout && n < 2000) begin
            step(1);
            n++;
        end
        check("to_wait_cycles", n, 32'd1024);
        check("to_gen_rst", {31'b0, gen_rst}, 32'd1);
        check("to_busy", {31'b0, busy}, 32'd0);
        check("to_locked", {31'b0, LOCKED}, 32'd0);

        // Lower-bound valid config clears timeout; then reset mid-COUNT together with PWRDWN
        period_stable = 1'b1;
        drive_req(32'd2, 32'd1, 32'd1, 1'b1, 32'd2, 32'd1, 32'd1);
        step(1);
        u_if.cfg_req = 1'b0;
        check("to_cleared", {31'b0, timeout}, 32'd0);
        wait_rst_low(n);
        step(3);
        check("count_busy", {31'b0, busy}, 32'd1);
        RST    = 1'b1;
        PWRDWN = 1'b1;
        step(1);
        check_reset_outputs("midrst");

        // Power-down before any accepted config stays idle afterwards
        RST = 1'b0;
        step(3);
        check("pd0_gen_pwrdwn", {31'b0, gen_pwrdwn}, 32'd1);
        PWRDWN = 1'b0;
        step(1);
        check("pd0rel_gen_pwrdwn", {31'b0, gen_pwrdwn}, 32'd0);
        check("pd0rel_busy", {31'b0, busy}, 32'd0);
        step(5);
        check("pd0_idle_busy", {31'b0, busy}, 32'd0);
        check("pd0_idle_gen_rst", {31'b0, gen_rst}, 32'd1);
        check("pd0_idle_locked", {31'b0, LOCKED}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
